// File: rtl/pyramid_bram_arbiter.sv
`default_nettype none
// =============================================================================
// pyramid_bram_arbiter : shares BRAM port B between pyramid builder and UART dumper
// Optional macro PYR_ARB_FIXED_PRIO_EN : fixed req0 priority instead of round-robin
// Revision : 1.0
// =============================================================================
module pyramid_bram_arbiter #(
   parameter int BIT_DEPTH  = 8,
   parameter int RAM_DEPTH  = 320*180,
   parameter int RD_LATENCY = 2
) (
   input  logic                          clk_100mhz,
   input  logic                          sys_rst_n,
   input  logic                          req0_valid,
   input  logic                          req0_we,
   input  logic [$clog2(RAM_DEPTH)-1:0]  req0_addr,
   input  logic [BIT_DEPTH-1:0]          req0_wdata,
   output logic                          req0_ready,
   output logic                          req0_rvalid,
   input  logic                          req1_valid,
   input  logic [$clog2(RAM_DEPTH)-1:0]  req1_addr,
   output logic                          req1_ready,
   output logic                          req1_rvalid,
   output logic [BIT_DEPTH-1:0]          rdata,
   output logic                          addr_err,
   output logic [$clog2(RAM_DEPTH)-1:0]  addrb,
   output logic [BIT_DEPTH-1:0]          dinb,
   output logic                          web,
   output logic                          enb,
   input  logic [BIT_DEPTH-1:0]          doutb
);

   localparam int                ADDR_W    = $clog2(RAM_DEPTH);
   localparam int                PIPE_W    = RD_LATENCY + 1;
   localparam logic [ADDR_W:0]   RANGE_LIM = (ADDR_W+1)'(RAM_DEPTH);

   logic                  w_grant0;
   logic                  w_grant1;
   logic                  w_accept;
   logic                  w_in_range;
   logic                  w_issue;
   logic                  w_sel_we;
   logic [ADDR_W-1:0]     w_sel_addr;
   logic                  w_ret_vld;
   logic                  w_ret_own;

   logic                  enb_q,         enb_d;
   logic                  web_q,         web_d;
   logic [ADDR_W-1:0]     addrb_q,       addrb_d;
   logic [BIT_DEPTH-1:0]  dinb_q,        dinb_d;
   logic                  addr_err_q,    addr_err_d;
   logic [PIPE_W-1:0]     tag_vld_q,     tag_vld_d;
   logic [PIPE_W-1:0]     tag_own_q,     tag_own_d;
   logic                  req0_rvalid_q, req0_rvalid_d;
   logic                  req1_rvalid_q, req1_rvalid_d;
   logic [BIT_DEPTH-1:0]  rdata_q,       rdata_d;

`ifdef PYR_ARB_FIXED_PRIO_EN
   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (sys_rst_n) begin
         w_grant0 = req0_valid;
         w_grant1 = req1_valid && !req0_valid;
      end
   end
`else
   // rr_q = 1 means req1 holds the turn on the next contention
   logic rr_q, rr_d;

   always_comb begin
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (sys_rst_n) begin
         if (req0_valid && req1_valid) begin
            w_grant0 = !rr_q;
            w_grant1 = rr_q;
         end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
         end
      end
   end

   always_comb begin
      rr_d = rr_q;
      if (req0_valid && req1_valid) begin
         rr_d = w_grant0;
      end
   end

   always_ff @(posedge clk_100mhz) begin
      if (!sys_rst_n) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end
`endif

   always_comb begin
      w_accept   = w_grant0 | w_grant1;
      w_sel_addr = w_grant0 ? req0_addr : req1_addr;
      w_sel_we   = w_grant0 & req0_we;
      w_in_range = ({1'b0, w_sel_addr} < RANGE_LIM);
      w_issue    = w_accept & w_in_range;
      w_ret_vld  = tag_vld_q[PIPE_W-1];
      w_ret_own  = tag_own_q[PIPE_W-1];
   end

   always_comb begin
      enb_d         = w_issue;
      web_d         = w_issue & w_sel_we;
      addrb_d       = w_issue ? w_sel_addr : addrb_q;
      dinb_d        = (w_issue && w_grant0) ? req0_wdata : dinb_q;
      addr_err_d    = w_accept & !w_in_range;
      // Read tags march alongside the BRAM latency; the last stage lines up with doutb
      tag_vld_d     = {tag_vld_q[PIPE_W-2:0], w_issue & !w_sel_we};
      tag_own_d     = {tag_own_q[PIPE_W-2:0], w_grant1};
      req0_rvalid_d = w_ret_vld & !w_ret_own;
      req1_rvalid_d = w_ret_vld & w_ret_own;
      rdata_d       = w_ret_vld ? doutb : rdata_q;
   end

   always_ff @(posedge clk_100mhz) begin
      if (!sys_rst_n) begin
         enb_q         <= 1'b0;
         web_q         <= 1'b0;
         addrb_q       <= '0;
         dinb_q        <= '0;
         addr_err_q    <= 1'b0;
         tag_vld_q     <= '0;
         tag_own_q     <= '0;
         req0_rvalid_q <= 1'b0;
         req1_rvalid_q <= 1'b0;
         rdata_q       <= '0;
      end else begin
         enb_q         <= enb_d;
         web_q         <= web_d;
         addrb_q       <= addrb_d;
         dinb_q        <= dinb_d;
         addr_err_q    <= addr_err_d;
         tag_vld_q     <= tag_vld_d;
         tag_own_q     <= tag_own_d;
         req0_rvalid_q <= req0_rvalid_d;
         req1_rvalid_q <= req1_rvalid_d;
         rdata_q       <= rdata_d;
      end
   end

   assign req0_ready  = w_grant0;
   assign req1_ready  = w_grant1;
   assign enb         = enb_q;
   assign web         = web_q;
   assign addrb       = addrb_q;
   assign dinb        = dinb_q;
   assign addr_err    = addr_err_q;
   assign req0_rvalid = req0_rvalid_q;
   assign req1_rvalid = req1_rvalid_q;
   assign rdata       = rdata_q;

endmodule
`default_nettype wire
